// File: rtl/perceptron_pipe_ctrl_if.sv
// Handshake, config and status bundle between the perceptron pipeline controller and its neighbours.
// master = source/sink/config side, slave = the controller.
interface perceptron_pipe_ctrl_if #(
    parameter int STAGES   = 2,
    parameter int CFG_BITS = 2
);
    localparam int OCC_W = $clog2(STAGES + 1);

    logic [CFG_BITS-1:0] cfg_en_i;
    logic                flush_i;
    logic                val_i;
    logic                rdy_o;
    logic                val_o;
    logic                rdy_i;
    logic [STAGES-1:0]   stage_en_o;
    logic [STAGES-1:0]   stage_val_o;
    logic [OCC_W-1:0]    occupancy_o;
    logic                cfg_grant_o;
    logic [1:0]          state_o;

    modport master (
        output cfg_en_i, flush_i, val_i, rdy_i,
        input  rdy_o, val_o, stage_en_o, stage_val_o, occupancy_o, cfg_grant_o, state_o
    );

    modport slave (
        input  cfg_en_i, flush_i, val_i, rdy_i,
        output rdy_o, val_o, stage_en_o, stage_val_o, occupancy_o, cfg_grant_o, state_o
    );
endinterface

// File: rtl/perceptron_pipe_ctrl.sv
// Valid/ready control for a STAGES-deep perceptron datapath plus weight-config arbitration; STAGES cycles accept->val_o.
// Backpressure ripples back through stage enables (any bubble lets upstream advance); config/flush block intake same cycle.
module perceptron_pipe_ctrl #(
    parameter int STAGES    = 2,
    parameter int CFG_BITS  = 2,
    parameter int CFG_FLUSH = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    perceptron_pipe_ctrl_if.slave bus
);
    localparam int OCC_W = $clog2(STAGES + 1);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        CFG_DRAIN = 2'd1,
        CFG_HOLD  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [STAGES-1:0]  v;
    logic [STAGES-1:0]  en;
    logic [OCC_W-1:0]   occ;
    logic               cfg_req;
    logic               rdy;
    logic               discard;
    logic               grant_q;
    logic               en_chain;

    assign cfg_req = |bus.cfg_en_i;

    // A stage may load when the sink takes data or any stage at or beyond it holds a bubble.
    always_comb begin
        en       = '0;
        en_chain = bus.rdy_i;
        for (int k = STAGES - 1; k >= 0; k--) begin
            en_chain = en_chain | ~v[k];
            en[k]    = en_chain;
        end
    end

    always_comb begin
        occ = '0;
        for (int k = 0; k < STAGES; k++) begin
            occ = occ + OCC_W'(v[k]);
        end
    end

    assign rdy     = en[0] & (state == RUN) & ~cfg_req & ~bus.flush_i & reset;
    assign discard = (CFG_FLUSH != 0) && (state == RUN) && cfg_req;

    always_comb begin
        state_nxt = state;
        case (state)
            RUN: begin
                if (cfg_req) begin
                    state_nxt = ((CFG_FLUSH != 0) || (occ == '0)) ? CFG_HOLD : CFG_DRAIN;
                end
            end
            CFG_DRAIN: begin
                if (!cfg_req) begin
                    state_nxt = RUN;
                end else if (occ == '0) begin
                    state_nxt = CFG_HOLD;
                end
            end
            CFG_HOLD: begin
                if (!cfg_req) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= RUN;
            grant_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            grant_q <= (state_nxt == CFG_HOLD);
        end
    end

    // Flush and flush-style config discard win over every capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v <= '0;
        end else if (bus.flush_i || discard) begin
            v <= '0;
        end else begin
            if (en[0]) begin
                v[0] <= bus.val_i & rdy;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (en[k]) begin
                    v[k] <= v[k-1];
                end
            end
        end
    end

    assign bus.rdy_o       = rdy;
    assign bus.val_o       = v[STAGES-1];
    assign bus.stage_en_o  = en;
    assign bus.stage_val_o = v;
    assign bus.occupancy_o = occ;
    assign bus.cfg_grant_o = grant_q;
    assign bus.state_o     = state;
endmodule

// File: tb/tb_perceptron_pipe_ctrl.sv
// Two controllers (2-stage drain-mode, 3-stage discard-mode) on shared stimulus, checked every cycle against a slot model.
module tb_perceptron_pipe_ctrl;
    logic       clk    = 1'b0;
    logic       reset  = 1'b0;
    logic [1:0] cfg_en = 2'b00;
    logic       flush  = 1'b0;
    logic       val_in = 1'b0;
    logic       rdy_in = 1'b0;

    int npass = 0;
    int ntot  = 0;
    int d0    = 0;
    int d1    = 0;

    always #5 clk = ~clk;

    perceptron_pipe_ctrl_if #(.STAGES(2), .CFG_BITS(2)) a0 ();
    perceptron_pipe_ctrl_if #(.STAGES(3), .CFG_BITS(2)) a1 ();

    assign a0.cfg_en_i = cfg_en;
    assign a0.flush_i  = flush;
    assign a0.val_i    = val_in;
    assign a0.rdy_i    = rdy_in;
    assign a1.cfg_en_i = cfg_en;
    assign a1.flush_i  = flush;
    assign a1.val_i    = val_in;
    assign a1.rdy_i    = rdy_in;

    perceptron_pipe_ctrl #(.STAGES(2), .CFG_BITS(2), .CFG_FLUSH(0)) u0 (
        .clk(clk), .reset(reset), .bus(a0.slave));
    perceptron_pipe_ctrl #(.STAGES(3), .CFG_BITS(2), .CFG_FLUSH(1)) u1 (
        .clk(clk), .reset(reset), .bus(a1.slave));

    // ---------------- reference model: occupied slots, index 0 = ingress ----------------
    logic [7:0] mv [2];
    int         mst [2];

    function automatic int stages_of(int i);
        return (i == 0) ? 2 : 3;
    endfunction

    // A slot may move forward when the sink takes data or there is free room at or after it.
    function automatic logic [7:0] m_en(logic [7:0] v, int s, logic rdyi);
        logic [7:0] e;
        logic       bub;
        e = '0;
        for (int k = 0; k < s; k++) begin
            bub = 1'b0;
            for (int j = k; j < s; j++) if (!v[j]) bub = 1'b1;
            e[k] = rdyi | bub;
        end
        return e;
    endfunction

    function automatic logic m_rdy(logic [7:0] v, int s, int st, logic [1:0] cfg,
                                   logic fl, logic rdyi, logic rs);
        logic [7:0] e;
        e = m_en(v, s, rdyi);
        return e[0] && (st == 0) && (cfg == 2'b00) && !fl && rs;
    endfunction

    function automatic logic [7:0] m_next_v(logic [7:0] v, int s, int st, logic flp,
                                            logic [1:0] cfg, logic fl, logic vi, logic rdyi);
        logic [7:0] e;
        logic [7:0] n;
        logic       r;
        e = m_en(v, s, rdyi);
        r = m_rdy(v, s, st, cfg, fl, rdyi, 1'b1);
        if (fl || (st == 0 && cfg != 2'b00 && flp)) return 8'h00;
        n = v;
        for (int k = s - 1; k >= 1; k--) if (e[k]) n[k] = v[k-1];
        if (e[0]) n[0] = vi & r;
        return n;
    endfunction

    function automatic int m_next_st(logic [7:0] v, int st, logic flp, logic [1:0] cfg);
        int occ;
        occ = $countones(v);
        if (st == 0) begin
            if (cfg == 2'b00) return 0;
            return (flp || occ == 0) ? 2 : 1;
        end
        if (st == 1) begin
            if (cfg == 2'b00) return 0;
            return (occ == 0) ? 2 : 1;
        end
        return (cfg == 2'b00) ? 0 : 2;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                mv[i]  <= 8'h00;
                mst[i] <= 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                mv[i]  <= m_next_v(mv[i], stages_of(i), mst[i], i == 1, cfg_en, flush, val_in, rdy_in);
                mst[i] <= m_next_st(mv[i], mst[i], i == 1, cfg_en);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        ntot++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic chk_inst(input int i, input int en, input int rdy, input int vo, input int sv,
                            input int occ, input int gr, input int st);
        int         s;
        logic [7:0] e;
        logic       r;
        s = stages_of(i);
        e = m_en(mv[i], s, rdy_in);
        r = m_rdy(mv[i], s, mst[i], cfg_en, flush, rdy_in, reset);
        if (!reset) e = m_en(8'h00, s, rdy_in);
        chk($sformatf("u%0d_stage_en", i), en, int'(e));
        chk($sformatf("u%0d_rdy_o", i), rdy, int'(r));
        chk($sformatf("u%0d_val_o", i), vo, int'(mv[i][s-1]));
        chk($sformatf("u%0d_stage_val", i), sv, int'(mv[i]));
        chk($sformatf("u%0d_occupancy", i), occ, $countones(mv[i]));
        chk($sformatf("u%0d_grant", i), gr, (mst[i] == 2) ? 1 : 0);
        chk($sformatf("u%0d_state", i), st, mst[i]);
    endtask

    // Single compare point per cycle, away from the active edge.
    always @(negedge clk) begin
        chk_inst(0, int'(a0.stage_en_o), int'(a0.rdy_o), int'(a0.val_o), int'(a0.stage_val_o),
                 int'(a0.occupancy_o), int'(a0.cfg_grant_o), int'(a0.state_o));
        chk_inst(1, int'(a1.stage_en_o), int'(a1.rdy_o), int'(a1.val_o), int'(a1.stage_val_o),
                 int'(a1.occupancy_o), int'(a1.cfg_grant_o), int'(a1.state_o));
        if (a0.val_o && a0.rdy_i) d0 <= d0 + 1;
        if (a1.val_o && a1.rdy_i) d1 <= d1 + 1;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int base0;
        int base1;
        int cfg_left;

        // reset state
        cyc(3);
        chk("rst_rdy_o", int'(a0.rdy_o), 0);
        chk("rst_state", int'(a1.state_o), 0);

        // 1: full-rate stream through 2 and 3 stages
        reset = 1'b1; val_in = 1'b1; rdy_in = 1'b1;
        base0 = d0; base1 = d1;
        cyc(3);
        chk("t1_occ_u0", int'(a0.occupancy_o), 2);
        chk("t1_val_u0", int'(a0.val_o), 1);
        chk("t1_occ_u1", int'(a1.occupancy_o), 3);
        chk("t1_model_occ", $countones(mv[0]), 2);
        cyc(2);
        val_in = 1'b0;
        cyc(4);
        chk("t1_deliv_u0", d0 - base0, 5);
        chk("t1_deliv_u1", d1 - base1, 5);

        // 2: full 3-stage pipe stalled, then released
        val_in = 1'b1; rdy_in = 1'b0;
        cyc(7);
        chk("t2_rdy_o", int'(a1.rdy_o), 0);
        chk("t2_stage_en", int'(a1.stage_en_o), 0);
        chk("t2_val_o", int'(a1.val_o), 1);
        rdy_in = 1'b1;
        #1;
        chk("t2_rdy_same_cycle", int'(a1.rdy_o), 1);
        base1 = d1;
        cyc(4);
        chk("t2_deliv", d1 - base1, 4);

        // 3: bubble pattern 101 under stall
        val_in = 1'b0; rdy_in = 1'b1;
        cyc(4);
        val_in = 1'b1; rdy_in = 1'b0;
        cyc(1);
        val_in = 1'b0;
        cyc(1);
        val_in = 1'b1;
        cyc(1);
        chk("t3_v", int'(a1.stage_val_o), 5);
        chk("t3_model_v", int'(mv[1]), 5);
        chk("t3_en", int'(a1.stage_en_o), 3);
        chk("t3_rdy", int'(a1.rdy_o), 1);
        cyc(1);
        chk("t3_v_full", int'(a1.stage_val_o), 7);
        chk("t3_rdy_full", int'(a1.rdy_o), 0);

        // 4: drain-mode config with two items in flight
        val_in = 1'b0; rdy_in = 1'b1;
        cyc(4);
        val_in = 1'b1;
        cyc(2);
        cfg_en = 2'b01;
        #1;
        chk("t4_rdy_blocked", int'(a0.rdy_o), 0);
        base0 = d0;
        cyc(1);
        chk("t4_drain", int'(a0.state_o), 1);
        cyc(2);
        chk("t4_hold", int'(a0.state_o), 2);
        chk("t4_grant", int'(a0.cfg_grant_o), 1);
        chk("t4_deliv", d0 - base0, 2);
        cfg_en = 2'b00;
        cyc(1);
        chk("t4_run", int'(a0.state_o), 0);
        chk("t4_grant_off", int'(a0.cfg_grant_o), 0);
        chk("t4_rdy_back", int'(a0.rdy_o), 1);

        // 5: discard-mode config with two items in flight
        val_in = 1'b0;
        cyc(4);
        val_in = 1'b1;
        cyc(2);
        cfg_en = 2'b10; val_in = 1'b0;
        base1 = d1;
        cyc(1);
        chk("t5_v", int'(a1.stage_val_o), 0);
        chk("t5_val_o", int'(a1.val_o), 0);
        chk("t5_hold", int'(a1.state_o), 2);
        chk("t5_grant", int'(a1.cfg_grant_o), 1);
        chk("t5_no_out", d1 - base1, 0);
        cfg_en = 2'b00;
        cyc(4);

        // 6: flush of full stalled pipes, then async reset mid-drain
        val_in = 1'b1; rdy_in = 1'b0;
        cyc(4);
        flush = 1'b1;
        cyc(1);
        flush = 1'b0;
        chk("t6_occ_u1", int'(a1.occupancy_o), 0);
        chk("t6_val_u1", int'(a1.val_o), 0);
        chk("t6_occ_u0", int'(a0.occupancy_o), 0);
        cyc(3);
        cfg_en = 2'b01; val_in = 1'b0;
        cyc(1);
        chk("t6_drain", int'(a0.state_o), 1);
        #2 reset = 1'b0;
        #1;
        chk("t6_rst_state", int'(a0.state_o), 0);
        chk("t6_rst_v", int'(a0.stage_val_o), 0);
        chk("t6_rst_rdy", int'(a0.rdy_o), 0);
        chk("t6_rst_grant", int'(a1.cfg_grant_o), 0);
        cfg_en = 2'b00;
        cyc(1);
        reset = 1'b1;

        // randomized traffic with config windows, flushes and occasional resets
        cfg_left = 0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            reset = 1'b1;
            if (cfg_left > 0) begin
                cfg_left--;
            end else if ($urandom_range(0, 19) == 0) begin
                cfg_en   = 2'($urandom_range(1, 3));
                cfg_left = $urandom_range(1, 15);
            end else begin
                cfg_en = 2'b00;
            end
            flush  = ($urandom_range(0, 31) == 0);
            val_in = ($urandom_range(0, 9) < 7);
            rdy_in = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 499) == 0) begin
                #2 reset = 1'b0;
            end
        end

        reset = 1'b1; cfg_en = 2'b00; flush = 1'b0; val_in = 1'b0; rdy_in = 1'b1;
        cyc(5);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
